// File: rtl/pipe_stage_buf.sv
// Pipeline-stage buffer: valid/ready payload register with flush, occupancy and stall counter.
// Define PIPE_SKID_EN to add a skid entry so in_ready becomes registered (no out_ready path).
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       level,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             main_v;
    logic [WIDTH-1:0] main_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_v && out_ready;

`ifdef PIPE_SKID_EN
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    assign in_ready = !skid_v;
    assign level    = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_v <= 1'b1;
                        main_d <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d <= in_data;
                    end else if (in_fire) begin
                        state  <= FULL;
                        skid_v <= 1'b1;
                        skid_d <= in_data;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                        main_v <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the skid entry simply promotes.
                    if (out_fire) begin
                        state  <= ONE;
                        skid_v <= 1'b0;
                        main_d <= skid_d;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end
`else
    assign in_ready = !main_v || out_ready;
    assign level    = {1'b0, main_v};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_v <= 1'b0;
            main_d <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_v <= 1'b0;
            main_d <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_v <= 1'b1;
                        main_d <= in_data;
                    end
                end
                ONE: begin
                    // An accept while holding implies the head drains in the same cycle.
                    if (in_fire) begin
                        main_d <= in_data;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                        main_v <= 1'b0;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_v <= 1'b0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (WIDTH=8, CNT_W=3); adapts to PIPE_SKID_EN.
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] level;
    logic       clr_cnt;
    logic [2:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; clr_cnt = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] exp_d;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'h11 + 8'(i);
            in_data = exp_d;
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
                errors++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d);
            end
            checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL stream_stall[%0d] got %0d want 0", i, stall_cnt); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin
            errors++; $display("FAIL stream_drain got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_ready_path();
        logic exp_rdy;
        in_valid = 1'b1; in_data = 8'h20; out_ready = 1'b0;
        step();
        in_data = 8'h21;
        #1;
`ifdef PIPE_SKID_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL ready_stalled got %b want %b", in_ready, exp_rdy); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_released got %b want 1", in_ready); end
`ifdef PIPE_SKID_EN
        // Registered in_ready: 0x21 already accepted into skid before out_ready rose on this cycle? No: accepted at next edge.
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h21 || level !== 2'd1) begin
            errors++; $display("FAIL ready_next got d=%h lvl=%0d want d=21 lvl=1", out_data, level);
        end
`else
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h21 || level !== 2'd1) begin
            errors++; $display("FAIL ready_next got d=%h lvl=%0d want d=21 lvl=1", out_data, level);
        end
`endif
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ready_drain got %b want 0", out_valid); end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_backpressure();
        clr_cnt = 1'b1; out_ready = 1'b1; step(); clr_cnt = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
        step();
        in_data = 8'hA1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got lvl=%0d rdy=%b want lvl=2 rdy=0", level, in_ready);
        end
        step();
        checks++; if (stall_cnt !== 3'd2) begin errors++; $display("FAIL bp_stall got %0d want 2", stall_cnt); end
        checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL bp_head0 got %h want a0", out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || level !== 2'd1) begin
            errors++; $display("FAIL bp_head1 got v=%b d=%h lvl=%0d want v=1 d=a1 lvl=1", out_valid, out_data, level);
        end
        step();
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 3'd2) begin
            errors++; $display("FAIL bp_done got v=%b stall=%0d want v=0 stall=2", out_valid, stall_cnt);
        end
    endtask
`endif

    task automatic test_flush();
        logic [2:0] exp_stall;
        clr_cnt = 1'b1; out_ready = 1'b1; step(); clr_cnt = 1'b0;
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL flush_clr got %0d want 0", stall_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB0;
        step();
        exp_stall = 3'd0;
`ifdef PIPE_SKID_EN
        in_data = 8'hB1;
        step();
        exp_stall = 3'd1;
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL flush_pre_level got %0d want 2", level); end
`endif
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL flush_out got v=%b d=%h want v=0 d=00", out_valid, out_data);
        end
        checks++; if (level !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got lvl=%0d rdy=%b want lvl=0 rdy=1", level, in_ready);
        end
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL flush_stall got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got %0d want 7", stall_cnt); end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", stall_cnt); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC0) begin
            errors++; $display("FAIL sat_data got v=%b d=%h want v=1 d=c0", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL arst_pre got %0d want 1", level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin
            errors++; $display("FAIL arst_now got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
        checks++; if (in_ready !== 1'b1 || out_data !== 8'h00 || stall_cnt !== 3'd0) begin
            errors++; $display("FAIL arst_vals got rdy=%b d=%h stall=%0d want rdy=1 d=00 stall=0", in_ready, out_data, stall_cnt);
        end
        #1 reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_path();
`ifdef PIPE_SKID_EN
        test_backpressure();
`endif
        test_flush();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
